// File: rtl/julia_iterate.sv
// julia_iterate: fixed-point Julia escape-time engine, one z^2+c step per clock; define JULIA_MAG_OUT_EN to add out_mag.
module julia_iterate #(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 12,
    parameter int MAX_ITER = 100,
    parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] z0_re,
    input  logic [DATA_W-1:0] z0_im,
    input  logic [DATA_W-1:0] c_re,
    input  logic [DATA_W-1:0] c_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] out_count,
    output logic              out_escaped
`ifdef JULIA_MAG_OUT_EN
    ,
    output logic [DATA_W-1:0] out_mag
`endif
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    localparam logic signed [2*DATA_W:0] FOUR = (2*DATA_W+1)'(4) << (2*FRAC_W);
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);
    state_t state, state_n;
    logic signed [DATA_W-1:0] zr, zi, cr, ci, nzr, nzi;
    logic signed [2*DATA_W-1:0] zr2, zi2, zrzi;
    logic signed [2*DATA_W:0] mag;
    logic [ITER_W-1:0] cnt;
    logic escape, finish;
    assign zr2    = (2*DATA_W)'(zr) * (2*DATA_W)'(zr);
    assign zi2    = (2*DATA_W)'(zi) * (2*DATA_W)'(zi);
    assign zrzi   = (2*DATA_W)'(zr) * (2*DATA_W)'(zi);
    assign mag    = (2*DATA_W+1)'(zr2) + (2*DATA_W+1)'(zi2);
    // only bits FRAC_W.. of the products survive, so 2*DATA_W-wide differences suffice
    assign nzr    = DATA_W'((zr2 - zi2) >>> FRAC_W) + cr;
    assign nzi    = DATA_W'(zrzi >>> (FRAC_W - 1)) + ci;
    assign escape = mag > FOUR;
    assign finish = escape || cnt == ITER_MAX;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
`ifdef JULIA_MAG_OUT_EN
    localparam logic signed [2*DATA_W:0] MAG_LIM = (2*DATA_W+1)'(1) << (DATA_W + FRAC_W);
    logic [DATA_W-1:0] mag_sat;
    assign mag_sat = (mag >= MAG_LIM) ? '1 : DATA_W'(mag >>> FRAC_W);
`endif
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_n;
    end
    always_comb begin
        state_n = state;
        state_n = (state == IDLE && in_valid)  ? ITER :
                  (state == ITER && finish)    ? DONE :
                  (state == DONE && out_ready) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            zr          <= '0;
            zi          <= '0;
            cr          <= '0;
            ci          <= '0;
            cnt         <= '0;
            out_count   <= '0;
            out_escaped <= 1'b0;
`ifdef JULIA_MAG_OUT_EN
            out_mag     <= '0;
`endif
        end else if (state == IDLE && in_valid) begin
            zr  <= z0_re;
            zi  <= z0_im;
            cr  <= c_re;
            ci  <= c_im;
            cnt <= '0;
        end else if (state == ITER && finish) begin
            out_count   <= escape ? cnt : ITER_MAX;
            out_escaped <= escape;
`ifdef JULIA_MAG_OUT_EN
            out_mag     <= mag_sat;
`endif
        end else if (state == ITER) begin
            zr  <= nzr;
            zi  <= nzi;
            cnt <= cnt + ITER_W'(1);
        end
    end
endmodule

// File: doc/julia_iterate.md
Name: julia_iterate

Overview:
- Fixed-point Julia-set escape-time engine.
- Sits directly upstream of the colour stage. Each accepted pixel is a start point z0 and a constant c; the block iterates z = z^2 + c one step per clock until escape or MAX_ITER.
- Emits the iteration count, which is the stability input of the colour stage.
- Valid/ready handshake on both sides; one pixel in flight.

Parameters:
- DATA_W, 16, signed two's-complement width of every coordinate.
- FRAC_W, 12, fractional bits (Q4.12 default; range [-8, 8)).
- MAX_ITER, 100, iteration cap; must equal the colour stage's iteration normaliser.
- ITER_W, $clog2(MAX_ITER+1), width of the count output.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  pixel job offered
- in_ready  out  1  block can accept a job
- z0_re  in  DATA_W  start point, real part (signed)
- z0_im  in  DATA_W  start point, imaginary part (signed)
- c_re  in  DATA_W  Julia constant, real part (signed)
- c_im  in  DATA_W  Julia constant, imaginary part (signed)
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_count  out  ITER_W  iterations completed before escape (stability)
- out_escaped  out  1  1 = escaped; 0 = hit MAX_ITER

Behaviour:
- One clock; reset is synchronous and active-high (port reset, clock clk). The polarity and synchronicity are fixed.
- Reset values:
  - state IDLE; in_ready = 1; out_valid = 0.
  - out_count = 0; out_escaped = 0; internal z and counter cleared.
  - Reset wins over every other event, including mid-iteration; the in-flight job is discarded with no output.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch z0 and c, clear cnt, go to ITER.
  - ITER: in_ready = 0. Each cycle, compute mag = zr*zr + zi*zi in full 2*DATA_W+1 precision, Q(2*FRAC_W), without truncation.
    - If mag > 4.0 (strictly greater): out_count = cnt, out_escaped = 1, go to DONE.
    - Else if cnt == MAX_ITER: out_count = MAX_ITER, out_escaped = 0, go to DONE.
    - Else: zr <= ((zr*zr - zi*zi) >>> FRAC_W) + c_re; zi <= ((2*zr*zi) >>> FRAC_W) + c_im; cnt <= cnt + 1.
  - DONE: out_valid = 1, in_ready = 0. Outputs are held stable until out_valid & out_ready, then go to IDLE.
- Arithmetic rules:
  - Products are full width. The right shift is arithmetic, truncating toward negative infinity.
  - The escape check precedes the update. With |z| <= 2 and |c| <= 2, the new z stays within range, so no saturation logic exists.
  - Inputs with |c_re| or |c_im| > 2.0 are out of contract.
- Latency: out_valid is first high (out_count + 1) cycles after the accepting edge.
  - Minimum 1 cycle (z0 already escaped).
  - Maximum MAX_ITER + 1 cycles.
- Throughput: one job at a time. in_ready returns high the cycle after the output handshake, so there is no same-cycle accept in DONE.
- in_valid while in_ready = 0 is ignored; the upstream source must hold its data.
- mag exactly equal to 4.0 does not escape.

Optional Feature:
- Macro JULIA_MAG_OUT_EN.
- Defined: adds port out_mag, out, DATA_W. It carries the final mag (from the terminating ITER cycle), shifted >>> FRAC_W, unsigned, saturated to 2^DATA_W-1. It has the same reset and hold rules as out_count. It feeds smooth-colouring downstream.
- Undefined: no port and no extra registers; behaviour is otherwise identical.

Test Plan:
- After reset, z0=(0,0), c=(0,0) -> out_count=100, out_escaped=0, out_valid high 101 cycles after accept.
- z0=(3.0,0) (0x3000), c=0 -> out_count=0, out_escaped=1, latency 1.
- z0=(2.0,0), c=0 -> first mag = 4.0, no escape; z=4.0; then escape -> out_count=1, out_escaped=1, latency 2.
- z0=(0,0), c=(-2.0,0) -> z cycles -2, 2, 2, ... with mag exactly 4.0 each step -> out_count=100, out_escaped=0 (strict-greater boundary).
- Backpressure: result ready, out_ready held 0 for 5 cycles -> out_valid, out_count and out_escaped stable and in_ready=0 throughout. Handshake on cycle 6 -> in_ready=1 the next cycle, and a new in_valid is accepted.
- Reset asserted for 1 cycle at iteration 40 of a 100-iteration job -> next cycle in_ready=1, out_valid=0, out_count=0. A new job z0=(3.0,0) then returns out_count=0 with no trace of the aborted job.
